// File: rtl/pca_accel_pkg.sv
// Shared constants and types for the PCA accelerator datapath blocks.
// Consumed by packed_matrix_row_streamer (optional macro: PCA_ROWSTREAM_DBUF_EN).
package pca_accel_pkg;

    localparam int PCA_MATRIX_SIZE = 4;
    localparam int PCA_DATA_WIDTH  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } rowstream_state_t;

endpackage

// File: rtl/packed_matrix_row_streamer.sv
// Streams a packed row-major matrix out one row per valid/ready beat.
// Define PCA_ROWSTREAM_DBUF_EN to add a pending matrix buffer for back-to-back throughput.
//
// state | meaning
// IDLE  | no active matrix, outputs driven 0
// DRAIN | active matrix being streamed, r_row is the row on out_row
module packed_matrix_row_streamer
    import pca_accel_pkg::*;
#(
    parameter int MATRIX_SIZE = PCA_MATRIX_SIZE,
    parameter int DATA_WIDTH  = PCA_DATA_WIDTH
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]   in_data,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    output logic [DATA_WIDTH-1:0]                           out_row [MATRIX_SIZE],
    output logic [$clog2(MATRIX_SIZE)-1:0]                  out_row_idx,
    output logic                                            out_last,
    output logic                                            out_valid,
    input  logic                                            out_ready
);

    localparam int                ROW_W    = $clog2(MATRIX_SIZE);
    localparam int                MAT_W    = MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH;
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(MATRIX_SIZE-1);

    rowstream_state_t   r_state;
    rowstream_state_t   w_state_nxt;
    logic [MAT_W-1:0]   r_active;
    logic [ROW_W-1:0]   r_row;

    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_row_last;
    logic               w_last_fire;
    logic               w_load_active;

    assign w_in_fire   = in_valid && in_ready;
    assign w_out_fire  = out_valid && out_ready;
    assign w_row_last  = (r_row == LAST_ROW);
    assign w_last_fire = w_out_fire && w_row_last;

`ifdef PCA_ROWSTREAM_DBUF_EN
    logic [MAT_W-1:0]   r_pend;
    logic               r_pend_valid;
    logic               w_reload;

    assign in_ready = !rst && !r_pend_valid;
    // Input goes straight to active when nothing is active or finishing with an empty pending slot.
    assign w_load_active = w_in_fire && ((r_state == IDLE) || (w_last_fire && !r_pend_valid));
    assign w_reload      = w_last_fire && (r_pend_valid || w_in_fire);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
        end else if (w_last_fire && r_pend_valid) begin
            r_pend_valid <= 1'b0;
        end else if (w_in_fire && (r_state == DRAIN) && !w_last_fire) begin
            r_pend       <= in_data;
            r_pend_valid <= 1'b1;
        end
    end
`else
    logic               w_reload;

    assign in_ready      = !rst && (r_state == IDLE);
    assign w_load_active = w_in_fire;
    assign w_reload      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_in_fire) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_last_fire && !w_reload) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= '0;
            r_row    <= '0;
        end else begin
            if (w_load_active) begin
                r_active <= in_data;
`ifdef PCA_ROWSTREAM_DBUF_EN
            end else if (w_last_fire && r_pend_valid) begin
                r_active <= r_pend;
`endif
            end
            if (w_load_active || w_last_fire) begin
                r_row <= '0;
            end else if (w_out_fire) begin
                r_row <= r_row + 1'b1;
            end
        end
    end

    assign out_valid   = (r_state == DRAIN);
    assign out_row_idx = out_valid ? r_row : '0;
    assign out_last    = out_valid && w_row_last;

    for (genvar c = 0; c < MATRIX_SIZE; c++) begin : g_col
        assign out_row[c] = out_valid
            ? r_active[(int'(r_row)*MATRIX_SIZE + c + 1)*DATA_WIDTH - 1 -: DATA_WIDTH]
            : '0;
    end

endmodule

// File: tb/tb_packed_matrix_row_streamer.sv
// Directed and randomized checks for packed_matrix_row_streamer (N=4, DW=8).
module tb_packed_matrix_row_streamer;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MW = N*N*DW;

    logic          clk;
    logic          rst;
    logic [MW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_row [N];
    logic [1:0]    out_row_idx;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;

    int n_checks = 0;
    int n_errors = 0;

    packed_matrix_row_streamer #(.MATRIX_SIZE(N), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_row(out_row), .out_row_idx(out_row_idx), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       in_valid;
        logic       out_ready;
        logic       exp_in_ready;
        logic       exp_valid;
        logic [1:0] exp_idx;
        logic       exp_last;
        int         exp_first;
    } vec_t;

    vec_t vecs [14];

    function automatic logic [MW-1:0] mk(input int base);
        logic [MW-1:0] m;
        m = '0;
        for (int i = 0; i < N*N; i++) m[i*DW +: DW] = DW'(i + base);
        return m;
    endfunction

    function automatic logic [N*DW-1:0] row_bits();
        logic [N*DW-1:0] r;
        for (int c = 0; c < N; c++) r[c*DW +: DW] = out_row[c];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected row: consecutive elements starting at 'first', or all zero when idle.
    task automatic check_row(input string name, input logic valid, input int first);
        logic [N*DW-1:0] e;
        e = '0;
        if (valid) for (int c = 0; c < N; c++) e[c*DW +: DW] = DW'(first + c);
        check(name, 64'(row_bits()), 64'(e));
    endtask

    logic [MW-1:0] sb_q [$];
    logic [MW-1:0] m_act;
    logic [N*DW-1:0] exp_r;
    int            sb_row;
    int            accepted;
    int            cyc;
    logic          s_in_fire, s_out_fire;
    logic [MW-1:0] s_in_data;

    initial begin
        //        inv ordy  ir  val idx last first
        vecs[0]  = '{1, 1, 1, 0, 0, 0, 0};
        vecs[1]  = '{0, 1, 0, 1, 0, 0, 1};
        vecs[2]  = '{0, 1, 0, 1, 1, 0, 5};
        vecs[3]  = '{0, 1, 0, 1, 2, 0, 9};
        vecs[4]  = '{0, 1, 0, 1, 3, 1, 13};
        vecs[5]  = '{1, 1, 1, 0, 0, 0, 0};
        vecs[6]  = '{0, 1, 0, 1, 0, 0, 1};
        vecs[7]  = '{0, 0, 0, 1, 1, 0, 5};
        vecs[8]  = '{0, 0, 0, 1, 1, 0, 5};
        vecs[9]  = '{0, 0, 0, 1, 1, 0, 5};
        vecs[10] = '{0, 1, 0, 1, 1, 0, 5};
        vecs[11] = '{0, 1, 0, 1, 2, 0, 9};
        vecs[12] = '{0, 1, 0, 1, 3, 1, 13};
        vecs[13] = '{0, 1, 1, 0, 0, 0, 0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = mk(1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 0);
        check("rst_valid", 64'(out_valid), 0);
        check("rst_idx", 64'(out_row_idx), 0);
        check("rst_last", 64'(out_last), 0);
        check_row("rst_row", 1'b0, 0);
        rst = 1'b0;

        // Basic streaming followed by backpressure at row 1.
        for (int v = 0; v < 14; v++) begin
            if (v > 0) @(negedge clk);
            in_valid = vecs[v].in_valid; out_ready = vecs[v].out_ready; in_data = mk(1);
            #1;
            check($sformatf("v%0d_in_ready", v), 64'(in_ready), 64'(vecs[v].exp_in_ready));
            check($sformatf("v%0d_valid", v), 64'(out_valid), 64'(vecs[v].exp_valid));
            check($sformatf("v%0d_idx", v), 64'(out_row_idx), 64'(vecs[v].exp_idx));
            check($sformatf("v%0d_last", v), 64'(out_last), 64'(vecs[v].exp_last));
            check_row($sformatf("v%0d_row", v), vecs[v].exp_valid, vecs[v].exp_first);
        end

`ifdef PCA_ROWSTREAM_DBUF_EN
        // Two matrices back to back: B lands in pending during A's drain.
        @(negedge clk);
        in_valid = 1'b1; in_data = mk(1); out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k == 0) in_data = mk(101);
            if (k == 1) in_valid = 1'b0;
            #1;
            if (k == 0) check("db_in_ready_empty", 64'(in_ready), 1);
            if (k == 1) check("db_in_ready_full", 64'(in_ready), 0);
            if (k < 8) begin
                check($sformatf("db_valid%0d", k), 64'(out_valid), 1);
                check($sformatf("db_idx%0d", k), 64'(out_row_idx), 64'(k % 4));
                check_row($sformatf("db_row%0d", k), 1'b1, (k < 4) ? 1 + 4*k : 101 + 4*(k-4));
            end else begin
                check("db_valid_end", 64'(out_valid), 0);
            end
        end
`else
        // Input offered during drain must wait for IDLE.
        @(negedge clk);
        in_valid = 1'b1; in_data = mk(1); out_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            in_data = mk(101);
            #1;
            check($sformatf("st_in_ready%0d", r), 64'(in_ready), 0);
            check($sformatf("st_idx%0d", r), 64'(out_row_idx), 64'(r));
            check_row($sformatf("st_row%0d", r), 1'b1, 1 + 4*r);
        end
        @(negedge clk);
        #1;
        check("st_idle_in_ready", 64'(in_ready), 1);
        check("st_idle_valid", 64'(out_valid), 0);
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            check($sformatf("st_b_valid%0d", r), 64'(out_valid), 1);
            check_row($sformatf("st_b_row%0d", r), 1'b1, 101 + 4*r);
        end
        @(negedge clk);
        #1;
        check("st_b_done", 64'(out_valid), 0);
`endif

        // Reset while row 2 is presented, with a second matrix offered.
        @(negedge clk);
        in_valid = 1'b1; in_data = mk(1); out_ready = 1'b1;
        @(negedge clk);
        in_data = mk(101);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("mr_idx_before", 64'(out_row_idx), 2);
        rst = 1'b1; in_valid = 1'b0;
        #1;
        check("mr_in_ready_rst", 64'(in_ready), 0);
        @(negedge clk);
        #1;
        check("mr_valid", 64'(out_valid), 0);
        check("mr_idx", 64'(out_row_idx), 0);
        check("mr_last", 64'(out_last), 0);
        check_row("mr_row", 1'b0, 0);
        rst = 1'b0;
        #1;
        check("mr_in_ready", 64'(in_ready), 1);
        @(negedge clk);
        #1;
        check("mr_no_rows", 64'(out_valid), 0);

        // Random sweep with a scoreboard of accepted matrices.
        accepted = 0; sb_row = 0; cyc = 0;
        while ((accepted < 100 || sb_q.size() != 0) && cyc < 5000) begin
            @(negedge clk);
            in_valid  = (accepted < 100) && ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            s_in_fire  = in_valid && in_ready;
            s_out_fire = out_valid && out_ready;
            s_in_data  = in_data;
            if (s_out_fire) begin
                if (sb_q.size() == 0) begin
                    check("sw_unexpected_row", 64'(out_valid), 0);
                end else begin
                    m_act = sb_q[0];
                    exp_r = m_act[sb_row*N*DW +: N*DW];
                    check("sw_row", 64'(row_bits()), 64'(exp_r));
                    check("sw_idx", 64'(out_row_idx), 64'(sb_row));
                    check("sw_last", 64'(out_last), 64'(sb_row == N-1));
                    if (sb_row == N-1) begin
                        sb_row = 0;
                        void'(sb_q.pop_front());
                    end else begin
                        sb_row++;
                    end
                end
            end
            if (s_in_fire) begin
                sb_q.push_back(s_in_data);
                accepted++;
            end
            @(posedge clk);
            cyc++;
        end
        check("sw_timeout", 64'(cyc < 5000), 1);
        check("sw_accepted", 64'(accepted), 100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
